dsi_unpacker: RTL and testbench
===============================

# dsi_unpacker

Inverse of the DSI byte packer. Accepts words of up to `g_input_bytes` bytes, each carrying a variable number of valid bytes, and emits byte groups of a size the consumer requests per cycle (1..`g_output_bytes`). Sits on the receive/readback path between a word-wide FIFO or lane deserializer and byte-group consumers such as the pixel unformatter and the packet header parser. Bytes leave in exactly the order they arrived; none are lost or duplicated except on an explicit flush.

## Interface
Parameters:
- `g_input_bytes`, 4, bytes per input word (1..4).
- `g_output_bytes`, 3, maximum bytes per output group (1..4).

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  reset; synchronous and active-high. The polarity and synchronicity are fixed.
- `d_i`  in  8*g_input_bytes  input word; stream byte 0 in `[7:0]`, byte 1 in `[15:8]`, and so on.
- `d_size_i`  in  4  valid bytes in `d_i`, 1..`g_input_bytes`; the valid bytes occupy the low bytes.
- `d_valid_i`  in  1  word present.
- `d_req_o`  out  1  unpacker can accept a word this cycle.
- `q_size_i`  in  3  requested group size, 1..`g_output_bytes`.
- `q_req_i`  in  1  consumer requests a group.
- `q_flush_i`  in  1  emit the remaining bytes as a partial group, then empty the buffer.
- `q_o`  out  8*g_output_bytes  group, MSB-first; see Operation.
- `q_valid_o`  out  g_output_bytes  per-byte valid mask; `q_valid_o[i]` is high when `i` is less than the number of bytes emitted.
- `d_empty_o`  out  1  buffer holds no bytes.

## Operation
- The byte buffer holds `c_buf_bytes` = 2·max(g_input_bytes, g_output_bytes)+2 bytes.
- `count` (5 bits) gives the bytes held; the oldest byte sits at buffer byte 0.
- Accept: `push` = `d_valid_i` && `d_req_o`. An asserted `d_valid_i` while `d_req_o` is low is ignored: no state change.
- Pop: `pop` = `q_req_i` && (`count` >= `q_size_i`) && !`q_flush_i`. Nothing happens when bytes are insufficient, and the request does not stall anything.
- Output ordering for an n-byte group, bytes b0..b(n-1) oldest first:
  - b_k goes to `q_o[8*(n-1-k) +: 8]`;
  - bytes n and above are 0;
  - `q_valid_o` = (1<<n)−1.
- Buffer update in one cycle:
  - `count_next` = `count` − (pop ? q_size_i : 0) + (push ? d_size_i : 0).
  - The buffer shifts right by the popped bytes.
  - The new word's bytes land at byte position (`count` − popped).
  - Bytes above `count_next` are held at 0.
- Flush (`q_flush_i` high):
  - if `count` > 0, emit min(`count`, `g_output_bytes`) oldest bytes as an n-byte group;
  - then `count` ← 0 and the buffer is cleared, even if more than `g_output_bytes` bytes were held. Excess bytes are discarded by design.
  - `d_req_o` is low during flush, so no push occurs.
  - With `count` = 0, flush produces no output.
- `d_req_o` = !`q_flush_i` && (`c_buf_bytes` − `count` + (pop ? q_size_i : 0) >= `g_input_bytes`). It is combinational from `q_req_i`, `q_size_i` and `q_flush_i`.
- `d_empty_o` = (`count` == 0), registered state.

## Timing
- Output latency is 1 cycle. A pop or flush at edge N drives `q_o` and `q_valid_o` in cycle N+1, for exactly one cycle.
- In all other cycles `q_valid_o` = 0 and `q_o` holds its last value.
- Throughput: one push and one pop per cycle, simultaneously. Sustained unpacking at full input rate is possible whenever `q_size_i` × pop rate ≥ input rate.
- A byte pushed at edge N can be popped by a request in cycle N+1 at the earliest.
- `q_size_i` may change every cycle; each pop uses the value sampled in its own cycle.
- Reset values: `count` = 0, buffer = 0, `q_o` = 0, `q_valid_o` = 0, `d_empty_o` = 1. `d_req_o` = 1 once `rst_i` is low, and it is forced 0 while `rst_i` is high.
- Reset mid-stream discards all buffered bytes, and any output scheduled for the next cycle is suppressed.
- `d_size_i` = 0, or a value above `g_input_bytes`, is illegal. It is treated as size 0: no bytes are pushed.

## Structure
- Shared package `dsi_pkg`: `c_max_word_bytes` = 4, the size-field widths (4-bit input size, 3-bit output size) and a `f_max` function for the buffer sizing.
- Sub-module `dsi_byte_extract`, combinational: takes the buffer low bytes and n, and returns the MSB-first group plus its mask. It is reused by the flush and pop paths.
- The top level holds the counter, the shift/merge datapath and the output registers.

## Test plan
- Single word `d_i`=0x44332211, size 4; `q_size_i`=3 request → `q_o`=0x112233 with mask 3'b111 one cycle later; `count`=1. Flush → `q_o`=0x000044, mask 3'b001, then `d_empty_o`=1.
- Continuous 4-byte words carrying an incrementing byte pattern, requests of 3 every cycle → output bytes contiguous and in order, and `d_req_o` never deadlocks. Check over 1000 random cycles against a scoreboard.
- Push and pop in the same cycle with `count`=2, `d_size_i`=4, `q_size_i`=2 → `count_next`=4 and ordering preserved.
- Buffer near full (`count`=8 with a 10-byte buffer), no pop → `d_req_o`=0, and an asserted `d_valid_i` is ignored. The same state with a pop of 3 → `d_req_o`=1.
- Request with insufficient bytes (`count`=1, `q_size_i`=3) → no output, state unchanged. Flush with `count`=5 → 3 bytes emitted with mask 3'b111, then `count`=0.
- `rst_i` asserted the cycle after a pop → `q_valid_o`=0 the next cycle and all state at reset values.

Source files
------------

// File: rtl/dsi_pkg.sv
// Shared constants and helpers for the DSI byte packer/unpacker family.
package dsi_pkg;

  localparam int unsigned c_max_word_bytes = 4;
  localparam int unsigned c_in_size_w      = 4;
  localparam int unsigned c_out_size_w     = 3;
  localparam int unsigned c_count_w        = 5;

  // Larger of two byte counts; used to size the byte buffer.
  function automatic int unsigned f_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dsi_byte_extract.sv
// Picks the n oldest buffer bytes and lays them out MSB-first with a valid mask.
module dsi_byte_extract
  import dsi_pkg::*;
#(
  parameter int unsigned g_output_bytes = 3
) (
  input  logic [8*g_output_bytes-1:0] buf_i,
  input  logic [c_out_size_w-1:0]     n_i,
  output logic [8*g_output_bytes-1:0] group_c_o,
  output logic [g_output_bytes-1:0]   mask_c_o
);

  // Oldest byte k lands at output byte n-1-k; positions at n and above stay zero.
  always_comb begin
    group_c_o = '0;
    mask_c_o  = '0;
    for (int unsigned i = 0; i < g_output_bytes; i++) begin
      if (i < 32'(n_i)) begin
        mask_c_o[i] = 1'b1;
        for (int unsigned k = 0; k < g_output_bytes; k++) begin
          if (k + i + 1 == 32'(n_i)) begin
            group_c_o[8*i +: 8] = buf_i[8*k +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/dsi_unpacker.sv
// Splits variable-size input words into consumer-sized MSB-first byte groups.
module dsi_unpacker
  import dsi_pkg::*;
#(
  parameter int unsigned g_input_bytes  = 4,
  parameter int unsigned g_output_bytes = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [8*g_input_bytes-1:0]  d_i,
  input  logic [c_in_size_w-1:0]      d_size_i,
  input  logic                        d_valid_i,
  output logic                        d_req_o,
  input  logic [c_out_size_w-1:0]     q_size_i,
  input  logic                        q_req_i,
  input  logic                        q_flush_i,
  output logic [8*g_output_bytes-1:0] q_o,
  output logic [g_output_bytes-1:0]   q_valid_o,
  output logic                        d_empty_o
);

  localparam int unsigned c_buf_bytes = 2 * f_max(g_input_bytes, g_output_bytes) + 2;
  localparam int unsigned c_buf_w     = 8 * c_buf_bytes;
  localparam int unsigned c_in_w      = 8 * g_input_bytes;
  localparam int unsigned c_out_w     = 8 * g_output_bytes;
  localparam int unsigned c_space_w   = c_count_w + 1;
  localparam int unsigned c_shift_w   = c_count_w + 3;

  logic [c_count_w-1:0]    count_q, count_d;
  logic [c_buf_w-1:0]      buf_q, buf_d;
  logic [c_out_w-1:0]      q_q, q_d;
  logic [g_output_bytes-1:0] q_valid_q, q_valid_d;
  logic                    empty_q, empty_d;

  logic                    d_size_ok_c;
  logic                    q_size_ok_c;
  logic                    pop_c;
  logic                    push_c;
  logic                    flush_out_c;
  logic [c_count_w-1:0]    pop_n_c;
  logic [c_count_w-1:0]    push_n_c;
  logic [c_count_w-1:0]    keep_n_c;
  logic [c_space_w-1:0]    space_c;
  logic [c_in_w-1:0]       word_c;
  logic [c_shift_w-1:0]    pop_shift_c;
  logic [c_shift_w-1:0]    keep_shift_c;
  logic [c_out_size_w-1:0] n_sel_c;
  logic [c_out_w-1:0]      group_c;
  logic [g_output_bytes-1:0] mask_c;

  // Request qualification, input acceptance and byte accounting.
  always_comb begin
    d_size_ok_c = (d_size_i != '0) && (32'(d_size_i) <= g_input_bytes);
    q_size_ok_c = (q_size_i != '0) && (32'(q_size_i) <= g_output_bytes);
    pop_c       = q_req_i && !q_flush_i && q_size_ok_c &&
                  (count_q >= c_count_w'(q_size_i));
    pop_n_c     = pop_c ? c_count_w'(q_size_i) : '0;
    // Room counts bytes freed by a same-cycle pop.
    space_c     = c_space_w'(c_buf_bytes) - c_space_w'(count_q) + c_space_w'(pop_n_c);
    d_req_o     = !rst_i && !q_flush_i && (space_c >= c_space_w'(g_input_bytes));
    push_c      = d_valid_i && d_req_o;
    // Illegal sizes are accepted but contribute no bytes.
    push_n_c    = (push_c && d_size_ok_c) ? c_count_w'(d_size_i) : '0;
    keep_n_c    = count_q - pop_n_c;
    flush_out_c = q_flush_i && (count_q != '0);
    n_sel_c     = q_flush_i
                ? ((count_q > c_count_w'(g_output_bytes)) ? c_out_size_w'(g_output_bytes)
                                                          : c_out_size_w'(count_q))
                : q_size_i;
  end

  dsi_byte_extract #(
    .g_output_bytes (g_output_bytes)
  ) u_extract (
    .buf_i     (buf_q[c_out_w-1:0]),
    .n_i       (n_sel_c),
    .group_c_o (group_c),
    .mask_c_o  (mask_c)
  );

  // Shift out popped bytes and merge the new word behind the kept ones.
  always_comb begin
    word_c = '0;
    for (int unsigned b = 0; b < g_input_bytes; b++) begin
      if (b < 32'(push_n_c)) begin
        word_c[8*b +: 8] = d_i[8*b +: 8];
      end
    end
    pop_shift_c  = {pop_n_c, 3'b000};
    keep_shift_c = {keep_n_c, 3'b000};
    buf_d        = (buf_q >> pop_shift_c) | (c_buf_w'(word_c) << keep_shift_c);
    count_d      = keep_n_c + push_n_c;
    if (q_flush_i) begin
      buf_d   = '0;
      count_d = '0;
    end
    empty_d = (count_d == '0);
  end

  // Output group: valid for one cycle after a pop or non-empty flush, otherwise held.
  always_comb begin
    q_d       = q_q;
    q_valid_d = '0;
    if (flush_out_c || pop_c) begin
      q_d       = group_c;
      q_valid_d = mask_c;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q   <= '0;
      buf_q     <= '0;
      q_q       <= '0;
      q_valid_q <= '0;
      empty_q   <= 1'b1;
    end else begin
      count_q   <= count_d;
      buf_q     <= buf_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      empty_q   <= empty_d;
    end
  end

  assign q_o       = q_q;
  assign q_valid_o = q_valid_q;
  assign d_empty_o = empty_q;

endmodule

// File: tb/tb_dsi_unpacker.sv
// Scoreboard bench for dsi_unpacker: directed vectors plus a long streaming run.
module tb_dsi_unpacker;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] d_i;
  logic [3:0]  d_size_i;
  logic        d_valid_i;
  logic        d_req_o;
  logic [2:0]  q_size_i;
  logic        q_req_i;
  logic        q_flush_i;
  logic [23:0] q_o;
  logic [2:0]  q_valid_o;
  logic        d_empty_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  mq[$];   // bytes held, oldest first
  logic [26:0] sb[$];   // expected {group, mask}

  always #5 clk = ~clk;

  dsi_unpacker #(
    .g_input_bytes  (4),
    .g_output_bytes (3)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .d_i       (d_i),
    .d_size_i  (d_size_i),
    .d_valid_i (d_valid_i),
    .d_req_o   (d_req_o),
    .q_size_i  (q_size_i),
    .q_req_i   (q_req_i),
    .q_flush_i (q_flush_i),
    .q_o       (q_o),
    .q_valid_o (q_valid_o),
    .d_empty_o (d_empty_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every presented group must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [26:0] e;
    if (q_valid_o !== 3'b000) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got %h/%b want none", q_o, q_valid_o);
      end else begin
        e = sb.pop_front();
        check("group", {5'd0, q_o, q_valid_o}, {5'd0, e});
      end
    end
  end

  // One clock of stimulus; hm != 0 supplies a hand-computed expected group.
  task automatic step(input logic rst, input logic vld, input logic [31:0] d,
                      input logic [3:0] ds, input logic req, input logic [2:0] qs,
                      input logic fl, input logic [23:0] hd, input logic [2:0] hm,
                      output bit pushed);
    int cnt, popn, n;
    logic exp_req;
    logic [23:0] g;
    logic [2:0] m;
    bit have;
    rst_i = rst; d_valid_i = vld; d_i = d; d_size_i = ds;
    q_req_i = req; q_size_i = qs; q_flush_i = fl;
    #1;
    cnt = mq.size();
    check("d_empty", {31'd0, d_empty_o}, {31'd0, cnt == 0});
    popn = (req && !fl && qs != 0 && cnt >= int'(qs)) ? int'(qs) : 0;
    exp_req = !rst && !fl && (10 - cnt + popn >= 4);
    check("d_req", {31'd0, d_req_o}, {31'd0, exp_req});
    have = 0; n = 0; g = '0; m = '0; pushed = 0;
    if (rst) begin
      mq.delete();
    end else begin
      if (fl && cnt > 0) n = (cnt < 3) ? cnt : 3;
      else if (popn > 0) n = popn;
      if (n > 0) begin
        for (int k = 0; k < n; k++) g = {g[15:0], mq[k]};
        m = 3'((1 << n) - 1);
        have = 1;
      end
      if (fl) mq.delete();
      else repeat (popn) void'(mq.pop_front());
      if (vld && exp_req) begin
        pushed = 1;
        if (ds >= 1 && ds <= 4)
          for (int b = 0; b < int'(ds); b++) mq.push_back(d[8*b +: 8]);
      end
      if (hm != 3'b000) sb.push_back({hd, hm});
      else if (have) sb.push_back({g, m});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit p;
    int n_push;
    logic [7:0] pat;
    rst_i = 1'b1; d_i = '0; d_size_i = '0; d_valid_i = 1'b0;
    q_size_i = 3'd3; q_req_i = 1'b0; q_flush_i = 1'b0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 3, 0, 0, 0, p);
    check("rst_q", {8'd0, q_o}, 0);
    check("rst_qv", {29'd0, q_valid_o}, 0);

    // Single word, pop of 3, flush of the remainder.
    step(0, 1, 32'h44332211, 4, 0, 3, 0, 0, 0, p);
    step(0, 0, 0, 4, 1, 3, 0, 24'h112233, 3'b111, p);
    step(0, 0, 0, 4, 0, 3, 1, 24'h000044, 3'b001, p);
    step(0, 0, 0, 4, 0, 3, 0, 0, 0, p);

    // Simultaneous push and pop with count 2.
    step(0, 1, 32'h0000BBAA, 2, 0, 3, 0, 0, 0, p);
    step(0, 1, 32'h04030201, 4, 1, 2, 0, 24'h00AABB, 3'b011, p);
    step(0, 0, 0, 4, 1, 3, 0, 24'h010203, 3'b111, p);
    step(0, 0, 0, 4, 0, 3, 1, 24'h000004, 3'b001, p);

    // Near full: push refused without a pop, accepted with a pop of 3.
    step(0, 1, 32'h14131211, 4, 0, 3, 0, 0, 0, p);
    step(0, 1, 32'h18171615, 4, 0, 3, 0, 0, 0, p);
    step(0, 1, 32'h28272625, 4, 0, 3, 0, 0, 0, p);
    step(0, 1, 32'h28272625, 4, 1, 3, 0, 24'h111213, 3'b111, p);
    step(0, 0, 0, 4, 1, 3, 0, 24'h141516, 3'b111, p);
    step(0, 0, 0, 4, 1, 3, 0, 24'h171825, 3'b111, p);
    step(0, 0, 0, 4, 0, 3, 1, 24'h262728, 3'b111, p);

    // Insufficient bytes, then flush of 5 held bytes keeps only 3.
    step(0, 1, 32'h00000055, 1, 0, 3, 0, 0, 0, p);
    step(0, 0, 0, 4, 1, 3, 0, 0, 0, p);
    step(0, 1, 32'h99887766, 4, 0, 3, 0, 0, 0, p);
    step(0, 0, 0, 4, 0, 3, 1, 24'h556677, 3'b111, p);
    step(0, 0, 0, 4, 0, 3, 0, 0, 0, p);

    // Illegal input sizes push nothing.
    step(0, 1, 32'hDEADBEEF, 0, 0, 3, 0, 0, 0, p);
    step(0, 1, 32'hDEADBEEF, 5, 0, 3, 0, 0, 0, p);
    step(0, 0, 0, 4, 0, 3, 0, 0, 0, p);

    // Reset the cycle after a pop; a coincident pop request is dropped.
    step(0, 1, 32'h0C0B0A09, 4, 0, 3, 0, 0, 0, p);
    step(0, 0, 0, 4, 1, 3, 0, 24'h090A0B, 3'b111, p);
    step(1, 0, 0, 4, 1, 1, 0, 0, 0, p);
    check("mid_rst_q", {8'd0, q_o}, 0);
    check("mid_rst_qv", {29'd0, q_valid_o}, 0);
    step(0, 0, 0, 4, 0, 3, 0, 0, 0, p);

    // Continuous 4-byte incrementing words, requests of 3 every cycle.
    pat = 8'h00;
    n_push = 0;
    for (int c = 0; c < 500; c++) begin
      step(0, 1, {pat + 8'd3, pat + 8'd2, pat + 8'd1, pat}, 4, 1, 3, 0, 0, 0, p);
      if (p) begin
        pat = pat + 8'd4;
        n_push++;
      end
    end
    check("no_deadlock", {31'd0, n_push > 300}, 1);

    // Random sizes, requests and occasional flushes.
    for (int c = 0; c < 500; c++) begin
      step(0, 1'($urandom_range(0, 1)), {pat + 8'd3, pat + 8'd2, pat + 8'd1, pat},
           4'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
           3'($urandom_range(1, 3)), 1'($urandom_range(0, 19) == 0), 0, 0, p);
      if (p) pat = pat + 8'd4;
    end

    repeat (3) step(0, 0, 0, 4, 0, 3, 0, 0, 0, p);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
